// File: rtl/cpu_step_ctrl.sv
// CPU clock generator with run/step/breakpoint control.
// Divides the system clock and gates CPU edges through a small FSM.
module cpu_step_ctrl #(
  parameter int DIV_HALF = 10,
  parameter int DEBOUNCE = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRun,
  input  logic        iStep,
  input  logic        iBpEn,
  input  logic [31:0] iBpAddr,
  input  logic [31:0] iPC,
  output logic        oCpuClk,
  output logic        oTick,
  output logic [1:0]  oState,
  output logic [31:0] oCycleCnt
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_BREAK = 2'b11;

  localparam logic [31:0] HALF_M1 = 32'(DIV_HALF - 1);
  localparam logic [7:0]  DB_M1   = 8'(DEBOUNCE - 1);

  logic       sync1;
  logic       sync2;
  logic       deb;
  logic [7:0] dcnt;
  logic       step_ev;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      dcnt  <= 8'd0;
    end else begin
      sync1 <= iStep;
      sync2 <= sync1;
      if (sync2 == deb) begin
        dcnt <= 8'd0;
      end else if (dcnt == DB_M1) begin
        deb  <= sync2;
        dcnt <= 8'd0;
      end else begin
        dcnt <= dcnt + 8'd1;
      end
    end
  end

  // One event per accepted press: only the low->high flip of deb fires.
  assign step_ev = sync2 & ~deb & (dcnt == DB_M1);

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic        cpu_clk;
  logic        clk_n;
  logic        tick;
  logic        tick_n;
  logic        first_rise;
  logic        first_n;
  logic        low_done;
  logic        done_n;
  logic [31:0] cycle_cnt;
  logic        due;
  logic        bp_hit;

  assign due    = (cnt == HALF_M1);
  assign bp_hit = iBpEn && (iPC == iBpAddr);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clk_n   = cpu_clk;
    tick_n  = 1'b0;
    first_n = first_rise;
    done_n  = low_done;
    unique case (state)
      S_IDLE: begin
        cnt_n = 32'd0;
        clk_n = 1'b0;
        if (iRun) begin
          state_n = S_RUN;
          first_n = 1'b1;
        end else if (step_ev) begin
          state_n = S_STEP;
          done_n  = 1'b0;
        end
      end
      S_RUN: begin
        if (!due) begin
          cnt_n = cnt + 32'd1;
        end else begin
          cnt_n = 32'd0;
          if (cpu_clk) begin
            clk_n = 1'b0;
            if (!iRun) state_n = S_IDLE;
          end else if (bp_hit && !first_rise) begin
            state_n = S_BREAK;
          end else begin
            clk_n   = 1'b1;
            tick_n  = 1'b1;
            first_n = 1'b0;
          end
        end
      end
      S_STEP: begin
        // Low, high, low: leave only after the trailing low half.
        if (!due) begin
          cnt_n = cnt + 32'd1;
        end else begin
          cnt_n = 32'd0;
          if (cpu_clk) begin
            clk_n  = 1'b0;
            done_n = 1'b1;
          end else if (low_done) begin
            state_n = S_IDLE;
          end else begin
            clk_n  = 1'b1;
            tick_n = 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_n = 32'd0;
        clk_n = 1'b0;
        if (!iRun) begin
          state_n = S_IDLE;
        end else if (step_ev) begin
          state_n = S_STEP;
          done_n  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= S_IDLE;
      cnt        <= 32'd0;
      cpu_clk    <= 1'b0;
      tick       <= 1'b0;
      first_rise <= 1'b0;
      low_done   <= 1'b0;
      cycle_cnt  <= 32'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cpu_clk    <= clk_n;
      tick       <= tick_n;
      first_rise <= first_n;
      low_done   <= done_n;
      if (tick) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign oCpuClk   = cpu_clk;
  assign oTick     = tick;
  assign oState    = state;
  assign oCycleCnt = cycle_cnt;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl (DIV_HALF=2, DEBOUNCE=3).
// Inputs driven and outputs sampled on the falling system-clock edge.
module tb_cpu_step_ctrl;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iRun;
  logic        iStep;
  logic        iBpEn;
  logic [31:0] iBpAddr;
  logic [31:0] iPC;
  logic        oCpuClk;
  logic        oTick;
  logic [1:0]  oState;
  logic [31:0] oCycleCnt;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_step_ctrl #(.DIV_HALF(2), .DEBOUNCE(3)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iRun      (iRun),
    .iStep     (iStep),
    .iBpEn     (iBpEn),
    .iBpAddr   (iBpAddr),
    .iPC       (iPC),
    .oCpuClk   (oCpuClk),
    .oTick     (oTick),
    .oState    (oState),
    .oCycleCnt (oCycleCnt)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRst  = 1'b1;
    iRun  = 1'b0;
    iStep = 1'b0;
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  // Run from PC 0 with breakpoint at 0x10: ticks at 0,4,8,C then BREAK.
  task automatic run_to_break();
    int ticks;
    ticks = 0;
    iPC   = 32'h0;
    iRun  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge iClk);
      if (oTick) begin
        ticks++;
        iPC = iPC + 32'd4;
      end
    end
    chk("bp_state", 32'(oState), 32'd3);
    chk("bp_ticks", ticks, 32'd4);
    chk("bp_cyc", oCycleCnt, 32'd4);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      if (oTick) ticks++;
    end
    chk("bp_hold_ticks", ticks, 32'd0);
    chk("bp_hold_clk", 32'(oCpuClk), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ticks;
    int hi;
    int step_cyc;
    int entries;
    int first_pc;
    logic [1:0] prev;
    logic seen;

    iRst    = 1'b0;
    iRun    = 1'b0;
    iStep   = 1'b0;
    iBpEn   = 1'b0;
    iBpAddr = 32'h0;
    iPC     = 32'h0;

    // asynchronous reset before any clock edge
    #2 iRst = 1'b1;
    #1;
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_clk", 32'(oCpuClk), 32'd0);
    chk("rst_tick", 32'(oTick), 32'd0);
    chk("rst_cyc", oCycleCnt, 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    repeat (3) @(negedge iClk);
    chk("idle_hold", 32'(oState), 32'd0);

    // run: period 4, first rise 2 cycles after entry
    iRun = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge iClk);
      chk("run_clk", 32'(oCpuClk), 32'((k % 4) >= 2));
      chk("run_tick", 32'(oTick), 32'((k % 4) == 2));
      chk("run_state", 32'(oState), 32'd1);
    end
    chk("run_cyc", oCycleCnt, 32'd5);
    iRun = 1'b0;
    @(negedge iClk);
    chk("run_stop_state", 32'(oState), 32'd0);
    chk("run_stop_clk", 32'(oCpuClk), 32'd0);

    // step with bounce
    do_reset();
    ticks = 0; hi = 0; step_cyc = 0; entries = 0;
    prev = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk);
      if (oTick) ticks++;
      if (oCpuClk) hi++;
      if (oState == 2'b10) step_cyc++;
      if (oState == 2'b10 && prev != 2'b10) entries++;
      prev  = oState;
      iStep = (i == 0) || (i == 2) || (i >= 4 && i <= 13);
    end
    chk("step_entries", entries, 32'd1);
    chk("step_ticks", ticks, 32'd1);
    chk("step_high", hi, 32'd2);
    chk("step_cycles", step_cyc, 32'd6);
    chk("step_state", 32'(oState), 32'd0);
    chk("step_cyc", oCycleCnt, 32'd1);

    // breakpoint, then step out of BREAK
    do_reset();
    iBpEn   = 1'b1;
    iBpAddr = 32'h10;
    run_to_break();
    ticks = 0; entries = 0;
    prev = oState;
    for (int i = 0; i < 30; i++) begin
      @(negedge iClk);
      if (oTick) begin
        ticks++;
        iPC = iPC + 32'd4;
      end
      if (oState == 2'b10 && prev == 2'b11) entries++;
      if (oState == 2'b10) iRun = 1'b0;
      prev  = oState;
      iStep = (i < 8);
    end
    chk("bstep_entries", entries, 32'd1);
    chk("bstep_ticks", ticks, 32'd1);
    chk("bstep_state", 32'(oState), 32'd0);
    chk("bstep_cyc", oCycleCnt, 32'd5);

    // re-run past the breakpoint
    do_reset();
    run_to_break();
    iRun = 1'b0;
    @(negedge iClk);
    chk("rerun_idle", 32'(oState), 32'd0);
    iRun = 1'b1;
    ticks = 0; first_pc = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge iClk);
      if (oTick) begin
        if (ticks == 0) first_pc = int'(iPC);
        ticks++;
        iPC = iPC + 32'd4;
      end
    end
    chk("rerun_first_pc", first_pc, 32'h10);
    chk("rerun_ticks", ticks, 32'd3);
    chk("rerun_state", 32'(oState), 32'd1);

    // async reset while the CPU clock is high
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      if (oCpuClk) begin
        seen = 1'b1;
        break;
      end
    end
    chk("areset_saw_high", 32'(seen), 32'd1);
    #2 iRst = 1'b1;
    #1;
    chk("areset_clk", 32'(oCpuClk), 32'd0);
    chk("areset_cyc", oCycleCnt, 32'd0);
    chk("areset_state", 32'(oState), 32'd0);
    chk("areset_tick", 32'(oTick), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    iRun = 1'b0;
    repeat (8) @(negedge iClk);
    chk("post_rst_state", 32'(oState), 32'd0);
    chk("post_rst_clk", 32'(oCpuClk), 32'd0);
    chk("post_rst_cyc", oCycleCnt, 32'd0);

    // cycle counter wrap
    iBpEn = 1'b0;
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    #1;
    chk("wrap_preset", oCycleCnt, 32'hFFFF_FFFF);
    @(negedge iClk);
    iRun = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      if (oTick) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wrap_tick", 32'(seen), 32'd1);
    @(negedge iClk);
    chk("wrap_cyc", oCycleCnt, 32'h0);
    iRun = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
